// File: rtl/irig_pkg.sv
// Shared constants, types and marker table for the IRIG-B pulse-width encoder.
package irig_pkg;

    localparam int unsigned DefCyclesBit  = 100000;
    localparam int unsigned DefCyclesZero = 20000;
    localparam int unsigned DefCyclesOne  = 50000;
    localparam int unsigned DefCyclesMark = 80000;

    localparam int unsigned FrameBits = 100;
    localparam int unsigned IdxW      = 7;
    localparam int unsigned NumMarks  = 11;

    localparam logic [IdxW-1:0] MarkIdx [NumMarks] = '{
        7'd0, 7'd9, 7'd19, 7'd29, 7'd39, 7'd49, 7'd59, 7'd69, 7'd79, 7'd89, 7'd99
    };

    typedef enum logic [1:0] {
        SymZero,
        SymOne,
        SymMark
    } irig_sym_e;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } irig_state_e;

    typedef struct packed {
        logic [7:0] year;
        logic [9:0] day;
        logic [5:0] hour;
        logic [6:0] min;
        logic [6:0] sec;
    } irig_time_t;

    function automatic logic is_marker(input logic [IdxW-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NumMarks; i++) begin
            if (idx == MarkIdx[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/irig_symbol_select.sv
// Maps a frame bit position and the latched time to the symbol sent at that position.
module irig_symbol_select
    import irig_pkg::*;
(
    input  logic [IdxW-1:0] bit_idx,
    input  irig_time_t      frame,
    output irig_sym_e       symbol
);

    logic [FrameBits-1:0] data;

    always_comb begin
        // BCD digits laid out LSB first; every unlisted position stays a binary 0
        data        = '0;
        data[4:1]   = frame.sec[3:0];
        data[8:6]   = frame.sec[6:4];
        data[13:10] = frame.min[3:0];
        data[17:15] = frame.min[6:4];
        data[23:20] = frame.hour[3:0];
        data[26:25] = frame.hour[5:4];
        data[33:30] = frame.day[3:0];
        data[38:35] = frame.day[7:4];
        data[41:40] = frame.day[9:8];
        data[53:50] = frame.year[3:0];
        data[58:55] = frame.year[7:4];

        if (is_marker(bit_idx)) begin
            symbol = SymMark;
        end else if (data[bit_idx]) begin
            symbol = SymOne;
        end else begin
            symbol = SymZero;
        end
    end

endmodule

// File: rtl/irig_width_encode.sv
// IRIG-B pulse-width encoder: frame sequencer, bit timing and double-buffered time register.
module irig_width_encode
    import irig_pkg::*;
#(
    parameter int unsigned CYCLES_BIT  = DefCyclesBit,
    parameter int unsigned CYCLES_ZERO = DefCyclesZero,
    parameter int unsigned CYCLES_ONE  = DefCyclesOne,
    parameter int unsigned CYCLES_MARK = DefCyclesMark
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       time_load,
    input  logic [6:0] time_sec,
    input  logic [6:0] time_min,
    input  logic [5:0] time_hour,
    input  logic [9:0] time_day,
    input  logic [7:0] time_year,
    output logic       irigb,
    output logic       frame_start,
    output logic       time_pending,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(CYCLES_BIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(CYCLES_BIT - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FrameBits - 1);

    irig_state_e     state_q, state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [IdxW-1:0] bit_idx_q, bit_idx_d;
    irig_time_t      shadow_q, shadow_d;
    irig_time_t      frame_q, frame_d;
    logic            pending_q, pending_d;
    logic            irigb_q, frame_start_q;

    irig_time_t      load_val;
    irig_sym_e       symbol;
    logic [CntW-1:0] high_last;
    logic            entry;

    irig_symbol_select u_symbol_select (
        .bit_idx (bit_idx_q),
        .frame   (frame_q),
        .symbol  (symbol)
    );

    always_comb begin
        load_val      = '0;
        load_val.sec  = time_sec;
        load_val.min  = time_min;
        load_val.hour = time_hour;
        load_val.day  = time_day;
        load_val.year = time_year;
    end

    always_comb begin
        case (symbol)
            SymMark: high_last = CntW'(CYCLES_MARK - 1);
            SymOne:  high_last = CntW'(CYCLES_ONE - 1);
            default: high_last = CntW'(CYCLES_ZERO - 1);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        entry     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d   = StHigh;
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    entry     = 1'b1;
                end
            end
            StHigh: begin
                bit_cnt_d = bit_cnt_q + CntW'(1);
                if (bit_cnt_q == high_last) begin
                    state_d = StLow;
                end
            end
            StLow: begin
                if (bit_cnt_q == LastCnt) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == LastIdx) begin
                        // enable is only consulted at frame boundaries
                        bit_idx_d = '0;
                        if (enable) begin
                            state_d = StHigh;
                            entry   = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IdxW'(1);
                        state_d   = StHigh;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        shadow_d  = shadow_q;
        frame_d   = frame_q;
        pending_d = pending_q;

        if (time_load) begin
            shadow_d = load_val;
        end

        if (entry) begin
            // a load landing on the transfer edge goes straight into the frame
            frame_d   = time_load ? load_val : shadow_q;
            pending_d = 1'b0;
        end else if (time_load) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shadow_q      <= '0;
            frame_q       <= '0;
            pending_q     <= 1'b0;
            irigb_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            pending_q     <= pending_d;
            irigb_q       <= (state_d == StHigh);
            frame_start_q <= entry;
        end
    end

    assign irigb        = irigb_q;
    assign frame_start  = frame_start_q;
    assign time_pending = pending_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_irig_width_encode.sv
// Randomized scoreboard bench for irig_width_encode with a frame-level reference model.
module tb_irig_width_encode;

    localparam int unsigned CB = 100;
    localparam int unsigned CZ = 20;
    localparam int unsigned CO = 50;
    localparam int unsigned CM = 80;
    localparam int FrameLen = 100 * CB;

    typedef struct packed {
        logic [7:0] year;
        logic [9:0] day;
        logic [5:0] hour;
        logic [6:0] min;
        logic [6:0] sec;
    } tb_time_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       time_load;
    logic [6:0] time_sec;
    logic [6:0] time_min;
    logic [5:0] time_hour;
    logic [9:0] time_day;
    logic [7:0] time_year;
    logic       irigb;
    logic       frame_start;
    logic       time_pending;
    logic       busy;

    int tests = 0;
    int fails = 0;

    irig_width_encode #(
        .CYCLES_BIT  (CB),
        .CYCLES_ZERO (CZ),
        .CYCLES_ONE  (CO),
        .CYCLES_MARK (CM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .time_load    (time_load),
        .time_sec     (time_sec),
        .time_min     (time_min),
        .time_hour    (time_hour),
        .time_day     (time_day),
        .time_year    (time_year),
        .irigb        (irigb),
        .frame_start  (frame_start),
        .time_pending (time_pending),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected 100-bit data content of a frame, straight from the field layout table
    function automatic logic [99:0] frame_bits(input tb_time_t v);
        logic [99:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            d[1 + i]  = v.sec[i];
            d[10 + i] = v.min[i];
            d[20 + i] = v.hour[i];
            d[30 + i] = v.day[i];
            d[35 + i] = v.day[4 + i];
            d[50 + i] = v.year[i];
            d[55 + i] = v.year[4 + i];
        end
        for (int i = 0; i < 3; i++) begin
            d[6 + i]  = v.sec[4 + i];
            d[15 + i] = v.min[4 + i];
        end
        for (int i = 0; i < 2; i++) begin
            d[25 + i] = v.hour[4 + i];
            d[40 + i] = v.day[8 + i];
        end
        return d;
    endfunction

    // Reference model: frame position as one integer, plus shadow/frame time values
    int       m_t = 0;
    bit       m_run = 0;
    bit       m_entry = 0;
    bit       m_pending = 0;
    tb_time_t m_shadow = '0;
    tb_time_t m_frame = '0;
    int       exp_q[$];

    always @(posedge clk) begin : model
        tb_time_t   in_v;
        logic [99:0] d;
        in_v.sec  = time_sec;
        in_v.min  = time_min;
        in_v.hour = time_hour;
        in_v.day  = time_day;
        in_v.year = time_year;
        m_entry = 0;
        if (!rst_n) begin
            m_run     = 0;
            m_t       = 0;
            m_pending = 0;
            m_shadow  = '0;
            m_frame   = '0;
            exp_q.delete();
        end else begin
            if (!m_run) begin
                m_entry = enable;
            end else if (m_t == FrameLen - 1) begin
                if (enable) m_entry = 1;
                else begin
                    m_run = 0;
                    m_t   = 0;
                end
            end else begin
                m_t++;
            end
            if (m_entry) begin
                m_run     = 1;
                m_t       = 0;
                m_frame   = time_load ? in_v : m_shadow;
                m_pending = 0;
                d = frame_bits(m_frame);
                for (int i = 0; i < 100; i++) begin
                    if (i == 0 || i % 10 == 9) exp_q.push_back(CM);
                    else if (d[i]) exp_q.push_back(CO);
                    else exp_q.push_back(CZ);
                end
            end
            if (time_load) begin
                m_shadow = in_v;
                if (!m_entry) m_pending = 1;
            end
        end
    end

    // Monitor: measures every high pulse and compares it against the scoreboard
    int hi_len = 0;
    bit prev_hi = 0;

    always @(posedge clk) begin : monitor
        int w;
        #2;
        if (!rst_n) begin
            hi_len  = 0;
            prev_hi = 0;
            check("reset irigb", int'(irigb), 0);
            check("reset busy", int'(busy), 0);
            check("reset time_pending", int'(time_pending), 0);
            check("reset frame_start", int'(frame_start), 0);
        end else begin
            check("busy", int'(busy), int'(m_run));
            check("time_pending", int'(time_pending), int'(m_pending));
            if (frame_start || m_entry) check("frame_start", int'(frame_start), int'(m_entry));
            if (!m_run) check("idle irigb", int'(irigb), 0);
            if (irigb) begin
                hi_len++;
            end else if (prev_hi) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected pulse: actual width %0d, required no pulse", hi_len);
                end else begin
                    w = exp_q.pop_front();
                    check("pulse width", hi_len, w);
                end
                hi_len = 0;
            end
            prev_hi = irigb;
        end
    end

    task automatic drive_time(input tb_time_t v);
        time_sec  = v.sec;
        time_min  = v.min;
        time_hour = v.hour;
        time_day  = v.day;
        time_year = v.year;
    endtask

    task automatic load(input tb_time_t v);
        drive_time(v);
        time_load = 1'b1;
        @(negedge clk);
        time_load = 1'b0;
    endtask

    function automatic tb_time_t rand_time();
        tb_time_t v;
        v.sec  = 7'($urandom);
        v.min  = 7'($urandom);
        v.hour = 6'($urandom);
        v.day  = 10'($urandom);
        v.year = 8'($urandom);
        return v;
    endfunction

    task automatic wait_pos(input int t);
        int n;
        n = 0;
        while (!(m_run && m_t == t)) begin
            @(negedge clk);
            n++;
            if (n > 2 * FrameLen) begin
                tests++;
                fails++;
                $display("FAIL timeout: frame position actual %0d, required %0d", m_t, t);
                return;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_run) begin
            @(negedge clk);
            n++;
            if (n > 2 * FrameLen) begin
                tests++;
                fails++;
                $display("FAIL timeout: run state actual 1, required 0");
                return;
            end
        end
    endtask

    initial begin
        tb_time_t v1;
        rst_n     = 1'b0;
        enable    = 1'b0;
        time_load = 1'b0;
        drive_time('0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        v1.sec  = 7'h59;
        v1.min  = 7'h07;
        v1.hour = 6'h23;
        v1.day  = 10'h366;
        v1.year = 8'h25;
        load(v1);
        enable = 1'b1;

        // mid-frame load goes to the next frame
        wait_pos(3000);
        load(rand_time());
        wait_pos(FrameLen - 1);
        @(negedge clk);

        // load on the final cycle of bit 99 bypasses into the following frame
        wait_pos(FrameLen - 1);
        load(rand_time());

        wait_pos(4000);
        enable = 1'b0;
        wait_idle();
        repeat (50) @(negedge clk);
        check("idle busy after drop", int'(busy), 0);
        check("idle irigb after drop", int'(irigb), 0);

        // reset in the high phase of bit 30, then restart with enable held
        load(rand_time());
        enable = 1'b1;
        wait_pos(3010);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("irigb after reset edge", int'(irigb), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        wait_pos(int'($urandom_range(100, 4000)));
        load(rand_time());
        wait_pos(int'($urandom_range(5000, 9000)));
        load(rand_time());
        wait_pos(FrameLen - 1);
        @(negedge clk);
        wait_pos(int'($urandom_range(1, FrameLen - 2)));
        enable = 1'b0;
        wait_idle();
        repeat (30) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        check("final busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time actual %0t, required completion", $time);
        $fatal(1);
    end

endmodule
